// File: rtl/prince_sbox_cf_compress.sv
// Masked PRINCE S-box stage after the CF array: register raw CF bits, then XOR-compress
// each group of three into one output share, with a two-deep valid/ready pipeline.
module prince_sbox_cf_compress #(
    parameter int unsigned NCOORD = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*NCOORD-1:0]   cf_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*NCOORD-1:0]   share_out
);

    logic [9*NCOORD-1:0] r1;
    logic [3*NCOORD-1:0] r2;
    logic [3*NCOORD-1:0] comp;
    logic                v1;
    logic                v2;
    logic                s1_adv;
    logic                accept;
    logic                load2;

    // Compression reads only the registered CF bits so no XOR ever sees raw CF glitches.
    for (genvar g = 0; g < NCOORD; g++) begin : g_coord
        for (genvar j = 0; j < 3; j++) begin : g_share
            assign comp[3*g+j] = ^r1[9*g+3*j +: 3];
        end
    end

    always_comb begin
        s1_adv   = !v2 || out_ready;
        in_ready = !flush && (!v1 || s1_adv);
        accept   = in_valid && in_ready;
        load2    = v1 && s1_adv;
    end

    // Data registers load only on a real transfer; bubbles keep old data to avoid extra share toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            r1 <= '0;
            r2 <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (accept) r1 <= cf_in;
            if (load2)  r2 <= comp;

            if (accept)     v1 <= 1'b1;
            else if (load2) v1 <= 1'b0;

            if (load2)          v2 <= 1'b1;
            else if (out_ready) v2 <= 1'b0;
        end
    end

    assign share_out = r2;
    assign out_valid = v2;

endmodule

// File: tb/tb_prince_sbox_cf_compress.sv
// Self-checking bench for prince_sbox_cf_compress: directed scenarios plus a scoreboard
// that checks every output handshake against beats recorded at acceptance.
module tb_prince_sbox_cf_compress;

    localparam int unsigned NCOORD = 3;
    localparam int unsigned WI = 9*NCOORD;
    localparam int unsigned WO = 3*NCOORD;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [WI-1:0] cf_in;
    logic          out_valid;
    logic          out_ready;
    logic [WO-1:0] share_out;

    int checks = 0;
    int errors = 0;
    logic [WO-1:0] sb[$];
    logic [WO-1:0] mon_exp;

    prince_sbox_cf_compress #(.NCOORD(NCOORD)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cf_in     (cf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .share_out (share_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [WO-1:0] compress(input logic [WI-1:0] x);
        logic [WO-1:0] r;
        r = '0;
        for (int g = 0; g < int'(NCOORD); g++)
            for (int j = 0; j < 3; j++)
                r[3*g+j] = x[9*g+3*j] ^ x[9*g+3*j+1] ^ x[9*g+3*j+2];
        return r;
    endfunction

    // Output monitor: every handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: share_out=%h with empty scoreboard", share_out);
            end else begin
                mon_exp = sb.pop_front();
                if (share_out !== mon_exp) begin
                    errors++;
                    $display("FAIL beat_data: share_out=%h expected=%h", share_out, mon_exp);
                end
            end
        end
    end

    task automatic send(input logic [WI-1:0] data);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        cf_in = data;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(compress(data));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b expected=1 within 20 cycles", in_ready);
        end
    endtask

    task automatic send_check_latency(input logic [WI-1:0] data, input logic [WO-1:0] exp);
        in_valid = 1'b1;
        cf_in = data;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_accept: in_ready=%b expected=1", in_ready);
        end
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: out_valid=%b expected=0 one cycle after accept", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || share_out !== exp) begin
            errors++;
            $display("FAIL lat_arrive: out_valid=%b share_out=%h expected 1/%h", out_valid, share_out, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 10 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || share_out !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b share_out=%h in_ready=%b expected 0/000/1",
                     out_valid, share_out, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mapping();
        out_ready = 1'b1;
        send_check_latency(27'h0000007, 9'h001);
        send_check_latency(27'h0000E00, 9'h008);
        send_check_latency(27'h7FFFFFF, 9'h1FF);
        send_check_latency(27'h0000003, 9'h000);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [WI-1:0] d[8];
        logic [31:0] rnd;
        for (int i = 0; i < 8; i++) begin
            rnd = $urandom();
            d[i] = rnd[WI-1:0];
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        cf_in = d[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready: beat %0d in_ready=%b expected=1", i, in_ready);
                end
                sb.push_back(compress(d[i]));
            end
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_valid: cycle %0d out_valid=%b expected=1", i, out_valid);
                end
            end
            @(posedge clk); #1;
            if (i + 1 < 8) cf_in = d[i+1];
            else in_valid = 1'b0;
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(27'h0000007);
        send(27'h7FFFFFF);
        in_valid = 1'b1;
        cf_in = 27'h0000E00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || share_out !== 9'h001) begin
                errors++;
                $display("FAIL stall: in_ready=%b out_valid=%b share_out=%h expected 0/1/001",
                         in_ready, out_valid, share_out);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(27'h0000E00);
        wait_drain();
    endtask

    task automatic test_bubble();
        logic [31:0] rnd;
        out_ready = 1'b1;
        send(27'h7FFFFFF);
        for (int i = 1; i <= 4; i++) begin
            rnd = $urandom();
            cf_in = rnd[WI-1:0];
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (share_out !== 9'h1FF || dut.r1 !== 27'h7FFFFFF || out_valid !== (i == 2)) begin
                    errors++;
                    $display("FAIL bubble_hold: cycle %0d share_out=%h r1=%h out_valid=%b expected 1ff/7ffffff/%b",
                             i, share_out, dut.r1, out_valid, i == 2);
                end
            end
            @(posedge clk); #1;
        end
        wait_drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(27'h7000000);
        send(27'h0000038);
        flush = 1'b1;
        in_valid = 1'b1;
        cf_in = 27'h0000E00;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b expected=0 during flush", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || share_out !== 9'h100) begin
            errors++;
            $display("FAIL flush_state: out_valid=%b in_ready=%b share_out=%h expected 0/1/100",
                     out_valid, in_ready, share_out);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_check_latency(27'h0000038, 9'h002);
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(27'h7FFFFFF);
        send(27'h0000007);
        rst = 1'b1;
        flush = 1'b1;
        in_valid = 1'b1;
        cf_in = 27'h0000E00;
        @(posedge clk); #1;
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || share_out !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_state: out_valid=%b share_out=%h in_ready=%b expected 0/000/1",
                     out_valid, share_out, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale: cycle %0d out_valid=%b expected=0", i, out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        cf_in = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_mapping();
        test_back_to_back();
        test_backpressure();
        test_bubble();
        test_flush();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
